fifo_byte_packer: RTL and testbench

FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

---
 rtl/fifo_pkg.sv | 12 +
 rtl/packer_out_reg.sv | 34 +++
 rtl/fifo_byte_packer.sv | 115 +++++++++++
 tb/tb_fifo_byte_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side byte packer.
package fifo_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_RATIO = 4;

  // Width needed to hold a lane count in the range 0..ratio inclusive.
  function automatic int lane_cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/packer_out_reg.sv
// Single-entry valid/ready holding register for the packed output word.
// 'free' means a load on this edge is safe: the slot is empty or is being taken.
module packer_out_reg #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         free
);

  assign free = !valid || ready;

  // A fresh word takes the slot; otherwise an accepted word retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_byte_packer.sv
// Packs RATIO consecutive DW-bit FIFO entries into one little-endian word.
// Optional partial-word flush is built when FIFO_BYTE_PACKER_FLUSH_EN is defined.
module fifo_byte_packer
  import fifo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int RATIO = DEF_RATIO
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [DW-1:0]       fifo_dout,
  input  logic                fifo_empty,
  output logic                fifo_re,
  input  logic                flush,
  output logic [DW*RATIO-1:0] out_data,
  output logic [RATIO-1:0]    out_be,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int            CW      = lane_cnt_w(RATIO);
  localparam int            OW      = DW * RATIO;
  localparam logic [CW:0]   RATIO_O = (CW+1)'(RATIO);

  logic [CW-1:0]            cnt, cnt_eff, cnt_base;
  logic                     pend;
  logic                     full, out_free, load, room;
  logic                     flush_lat, flush_fire;
  logic [CW:0]              occ;
  logic [RATIO-1:0][DW-1:0] asm_q;
  logic [RATIO-1:0]         load_be;
  logic [OW-1:0]            load_data;
  logic [OW+RATIO-1:0]      reg_q;

  assign full     = (cnt == CW'(RATIO));
  // A complete word that moves out this edge no longer occupies the assembly.
  assign cnt_eff  = (full && out_free) ? '0 : cnt;
  assign occ      = {1'b0, cnt_eff} + {{CW{1'b0}}, pend};
  // Look-ahead: with the last byte in flight and the output slot free now,
  // the word is certain to load on the edge the new byte lands, so one more
  // read may be issued; this is what keeps a byte per clock flowing.
  assign room     = (occ < RATIO_O) || ((occ == RATIO_O) && !full && out_free);
  assign fifo_re  = !fifo_empty && !clr && !rst && room && !flush_lat;
  assign load     = (full && out_free) || flush_fire;
  assign cnt_base = load ? '0 : cnt;
  assign busy     = (cnt != '0) || pend || out_valid;

`ifdef FIFO_BYTE_PACKER_FLUSH_EN
  assign flush_fire = flush_lat && (cnt != '0) && !pend && out_free;

  // Flush request latch; a request with nothing assembled or in flight is dropped.
  always_ff @(posedge clk) begin
    if (rst || clr)
      flush_lat <= 1'b0;
    else
      flush_lat <= ((cnt != '0) || pend) && (flush || (flush_lat && !flush_fire));
  end

  // Lane-valid mask covers only the lanes filled so far.
  always_comb begin
    load_be = '0;
    for (int k = 0; k < RATIO; k++)
      load_be[k] = (CW'(k) < cnt);
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_lat    = 1'b0;
  assign flush_fire   = 1'b0;
  assign load_be      = '1;
`endif

  // Unfilled lanes of a partial word go out as zero.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign load_data[k*DW +: DW] = load_be[k] ? asm_q[k] : '0;
  end

  // Assembly lanes: the returning byte goes to the next free lane, lane 0 if a word leaves.
  always_ff @(posedge clk) begin
    for (int k = 0; k < RATIO; k++)
      if (pend && (cnt_base == CW'(k)))
        asm_q[k] <= fifo_dout;
  end

  // Lane count and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      pend <= fifo_re;
      cnt  <= cnt_base + CW'(pend);
    end
  end

  packer_out_reg #(
    .W (OW + RATIO)
  ) u_out_reg (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load  (load),
    .din   ({load_be, load_data}),
    .ready (out_ready),
    .valid (out_valid),
    .dout  (reg_q),
    .free  (out_free)
  );

  assign out_data = reg_q[OW-1:0];
  assign out_be   = reg_q[OW +: RATIO];

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed + random bench for fifo_byte_packer with a FIFO model and output scoreboard.
module tb_fifo_byte_packer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clr, flush, out_ready, hold_empty;
  logic        fifo_empty, fifo_re, out_valid, busy;
  logic [7:0]  fifo_dout = '0;
  logic [31:0] out_data;
  logic [3:0]  out_be;

  logic [7:0]  mem [0:2047];
  int          wr = 0, rd = 0;
  exp_t        sb[$];
  exp_t        e;
  int          checks = 0, errors = 0, viol = 0, words_rx = 0, words_tx = 0;
  int          re_cnt, chg, n;
  logic [11:0] re_mask, vmask;
  logic [31:0] rw;

  always #5 clk = ~clk;

  fifo_byte_packer #(.DW(8), .RATIO(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .flush      (flush),
    .out_data   (out_data),
    .out_be     (out_be),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  // FIFO model, one-clock read latency
  assign fifo_empty = hold_empty || (rd == wr);
  always @(posedge clk)
    if (fifo_re && (rd != wr)) begin
      fifo_dout <= mem[rd];
      rd        <= rd + 1;
    end

  // output monitor / scoreboard
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (fifo_re && fifo_empty) viol++;
      if (out_valid && out_ready) begin
        words_rx++;
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_word got=%h be=%b exp=none", out_data, out_be);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          assert (out_data === e.data && out_be === e.be) else begin
            errors++;
            $error("FAIL word got=%h be=%b exp=%h be=%b", out_data, out_be, e.data, e.be);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr] = b;
    wr++;
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [3:0] be);
    sb.push_back('{data: w, be: be});
    words_tx++;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [3:0] be);
    for (int i = 0; i < 4; i++) push_byte(w[i*8 +: 8]);
    expect_word(w, be);
  endtask

  task automatic wait_sb_empty(input int maxc, input string tag);
    int c;
    c = 0;
    while (sb.size() != 0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s timeout left=%0d exp=0", tag, sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; flush = 1'b0; out_ready = 1'b1; hold_empty = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_be",    out_be,    0);
    chk("rst_busy",  busy,      0);
    chk("rst_re",    fifo_re,   0);
    rst = 1'b0;

    // bytes 01..08 streaming with ready high
    push_word(32'h04030201, 4'hF);
    push_word(32'h08070605, 4'hF);
    @(negedge clk);
    hold_empty = 1'b0;
    #1;
    re_mask = '0; vmask = '0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      re_mask[i] = fifo_re;
      vmask[i]   = out_valid;
    end
    chk("t1_re_pattern",    re_mask, 12'h0FF);
    chk("t1_valid_pattern", vmask,   12'h440);
    wait_sb_empty(20, "t1_drain");

    // backpressure: 12 bytes queued, output stalled
    out_ready = 1'b0; hold_empty = 1'b1;
    push_word(32'h14131211, 4'hF);
    push_word(32'h18171615, 4'hF);
    push_word(32'h1C1B1A19, 4'hF);
    @(negedge clk);
    hold_empty = 1'b0;
    #1;
    re_cnt = 0; chg = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (fifo_re) re_cnt++;
      if (out_valid && out_data !== 32'h14131211) chg++;
    end
    chk("t2_read_count", re_cnt,    8);
    chk("t2_data_moves", chg,       0);
    chk("t2_valid_held", out_valid, 1);
    chk("t2_data_held",  out_data,  32'h14131211);
    out_ready = 1'b1;
    wait_sb_empty(60, "t2_drain");

    // random empty / ready over 1000 bytes
    hold_empty = 1'b1;
    for (int w = 0; w < 250; w++) begin
      rw = $urandom;
      push_word(rw, 4'hF);
    end
    n = 0;
    while (sb.size() != 0 && n < 8000) begin
      @(negedge clk);
      hold_empty = ($urandom_range(0, 2) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      n++;
    end
    hold_empty = 1'b0; out_ready = 1'b1;
    wait_sb_empty(20, "t3_drain");
    chk("t3_empty_reads", viol, 0);

    // clr with two lanes filled and one read in flight
    hold_empty = 1'b1;
    push_byte(8'hA0); push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    @(negedge clk);
    hold_empty = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("t4_re_in_clr",   fifo_re, 0);
    chk("t4_busy_before", busy,    1);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("t4_valid_after", out_valid, 0);
    chk("t4_busy_after",  busy,      0);
    push_byte(8'hB1); push_byte(8'hB2); push_byte(8'hB3);
    expect_word(32'hB3B2B1A3, 4'hF);
    wait_sb_empty(20, "t4_lane0");

    // flush after a partial word
    hold_empty = 1'b1;
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
`ifdef FIFO_BYTE_PACKER_FLUSH_EN
    expect_word(32'h00CCBBAA, 4'b0111);
`endif
    @(negedge clk);
    hold_empty = 1'b0;
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
`ifdef FIFO_BYTE_PACKER_FLUSH_EN
    wait_sb_empty(20, "t5_flush_word");
    push_word(32'h11FFEEDD, 4'hF);
    wait_sb_empty(20, "t5_after_flush");
`else
    repeat (10) @(negedge clk);
    #1;
    chk("t5_no_output", out_valid, 0);
    chk("t5_holding",   busy,      1);
    push_byte(8'hDD);
    expect_word(32'hDDCCBBAA, 4'hF);
    wait_sb_empty(20, "t5_fourth_byte");
`endif

    // reset mid-word with a word held at the output
    out_ready = 1'b0; hold_empty = 1'b1;
    for (int i = 0; i < 6; i++) push_byte(8'h31 + 8'(i));
    @(negedge clk);
    hold_empty = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("t6_valid_before", out_valid, 1);
    chk("t6_data_before",  out_data,  32'h34333231);
    chk("t6_busy_before",  busy,      1);
    hold_empty = 1'b1;
    push_word(32'h44434241, 4'hF);
    @(negedge clk);
    rst = 1'b1; hold_empty = 1'b0;
    #1;
    chk("t6_re_in_rst", fifo_re, 0);
    @(negedge clk);
    #1;
    chk("t6_valid_rst", out_valid, 0);
    chk("t6_data_rst",  out_data,  0);
    chk("t6_be_rst",    out_be,    0);
    chk("t6_busy_rst",  busy,      0);
    rst = 1'b0; out_ready = 1'b1;
    wait_sb_empty(30, "t6_restart");

    chk("words_total", words_rx, words_tx);
    chk("empty_reads", viol,     0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
